// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the RV32M multiply/divide unit:
//   - FUNCT7_MULDIV and the func3 opcodes F3_MUL .. F3_REMU
//   - FSM state encoding (plain localparam constants)
//   - operand signedness helpers used when converting operands to magnitudes
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM. MUL is taken as
  // unsigned because its low product half does not depend on signedness.
  function automatic logic src_a_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: src_a_signed = 1'b1;
      default:                            src_a_signed = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM only.
  function automatic logic src_b_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_DIV, F3_REM: src_b_signed = 1'b1;
      default:                 src_b_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the execute stage and muldiv_unit.
//   master (pipeline): drives start_in, func7, func3, op_a, op_b
//   slave  (unit)    : drives ready_out, busy_out, done_out, result_out,
//                      illegal_out
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_in;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            ready_out;
  logic            busy_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;
  logic            illegal_out;

  modport master (
    output start_in, func7, func3, op_a, op_b,
    input  ready_out, busy_out, done_out, result_out, illegal_out
  );

  modport slave (
    input  start_in, func7, func3, op_a, op_b,
    output ready_out, busy_out, done_out, result_out, illegal_out
  );
endinterface

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Restoring divider over unsigned magnitudes, one quotient bit per step.
// Only instantiated when DIVIDER_EN is defined.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : capture dividend_i/divisor_i, clear the partial remainder
//   step_i        : perform one shift-subtract iteration
//   dividend_i    : dividend magnitude
//   divisor_i     : divisor magnitude (never zero; zero is handled upstream)
//   quotient_o    : quotient magnitude after XLEN steps
//   remainder_o   : remainder magnitude after XLEN steps
// -----------------------------------------------------------------------------
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   trial_s;
  logic [XLEN:0]   diff_s;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  // The partial remainder is always below the divisor, so the trial value is
  // below 2*divisor and the difference MSB is a clean borrow flag.
  always_comb begin
    trial_s = {rem_q, quo_q[XLEN-1]};
    diff_s  = trial_s - {1'b0, dvsr_q};
  end

  // Quotient/remainder registers: load, then one restoring step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      if (!diff_s[XLEN]) begin
        rem_q <= diff_s[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= trial_s[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit with a start/ready/done handshake.
// Multiply: radix-2 shift-add on magnitudes, XLEN iterations, then sign fix.
// Divide  : restoring divider (muldiv_div_core), XLEN iterations, sign fix.
// Illegal requests, divide-by-zero and signed overflow finish one cycle after
// accept without iterating.
//
// Configuration macro: DIVIDER_EN
//   defined   : DIV/DIVU/REM/REMU supported
//   undefined : divider not built; func3[2] = 1 requests report illegal_out
//
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high reset, aborts any operation
//   bus    : muldiv_unit_if.slave (start_in/func7/func3/op_a/op_b in,
//            ready_out/busy_out/done_out/result_out/illegal_out out)
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2:0]        f3_q,      f3_d;
  logic              neg_q,     neg_d;
  logic [XLEN-1:0]   mcand_q,   mcand_d;
  logic [2*XLEN-1:0] prod_q,    prod_d;
  logic [XLEN-1:0]   result_q,  result_d;
  logic              ready_q,   ready_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              illegal_q, illegal_d;

  logic              accept_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN:0]     addend_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   fix_res_s;

`ifdef DIVIDER_EN
  logic              rneg_q, rneg_d;
  logic              div_load_s;
  logic              div_step_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic [XLEN-1:0]   div_quo_s;
  logic [XLEN-1:0]   div_rem_s;

  muldiv_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (div_load_s),
    .step_i      (div_step_s),
    .dividend_i  (a_mag_s),
    .divisor_i   (b_mag_s),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s)
  );

  // Special-case detection on the incoming request.
  always_comb begin
    div_zero_s = (bus.op_b == '0);
    div_ovf_s  = src_a_signed(bus.func3) && (bus.op_a == MOST_NEG) &&
                 (bus.op_b == {XLEN{1'b1}});
  end
`endif

  assign accept_s = bus.start_in && ready_q;

  // Convert incoming operands to magnitudes according to func3 signedness.
  always_comb begin
    a_neg_s = src_a_signed(bus.func3) && bus.op_a[XLEN-1];
    b_neg_s = src_b_signed(bus.func3) && bus.op_b[XLEN-1];
    if (a_neg_s) begin
      a_mag_s = -bus.op_a;
    end else begin
      a_mag_s = bus.op_a;
    end
    if (b_neg_s) begin
      b_mag_s = -bus.op_b;
    end else begin
      b_mag_s = bus.op_b;
    end
  end

  // One shift-add step: the multiplier sits in the low half of the product
  // register and is consumed LSB first while partial sums enter from the top.
  always_comb begin
    if (prod_q[0]) begin
      addend_s = {1'b0, mcand_q};
    end else begin
      addend_s = '0;
    end
    mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} + addend_s;
    mul_next_s = {mul_sum_s, prod_q[XLEN-1:1]};
  end

  // Apply RISC-V sign rules and select the architectural result half.
  always_comb begin
    if (neg_q) begin
      prod_fix_s = -prod_q;
    end else begin
      prod_fix_s = prod_q;
    end
    case (f3_q)
      F3_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
`ifdef DIVIDER_EN
      F3_DIV, F3_DIVU:              fix_res_s = neg_q  ? -div_quo_s : div_quo_s;
      F3_REM, F3_REMU:              fix_res_s = rneg_q ? -div_rem_s : div_rem_s;
`endif
      default:                      fix_res_s = '0;
    endcase
  end

  // Control FSM next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = result_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef DIVIDER_EN
    rneg_d     = rneg_q;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          f3_d    = bus.func3;
          neg_d   = a_neg_s ^ b_neg_s;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef DIVIDER_EN
          rneg_d  = a_neg_s;
`endif
          if (bus.func7 != FUNCT7_MULDIV) begin
            state_d   = ST_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end else if (bus.func3[2]) begin
`ifdef DIVIDER_EN
            if (div_zero_s) begin
              // REM*/0 returns the dividend, DIV*/0 returns all ones.
              state_d  = ST_DONE;
              result_d = bus.func3[1] ? bus.op_a : {XLEN{1'b1}};
              done_d   = 1'b1;
            end else if (div_ovf_s) begin
              state_d  = ST_DONE;
              result_d = bus.func3[1] ? {XLEN{1'b0}} : bus.op_a;
              done_d   = 1'b1;
            end else begin
              state_d    = ST_DIV;
              cnt_d      = ITER_INIT;
              div_load_s = 1'b1;
            end
`else
            state_d   = ST_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
            done_d    = 1'b1;
`endif
          end else begin
            state_d = ST_MUL;
            cnt_d   = ITER_INIT;
            mcand_d = a_mag_s;
            prod_d  = {{XLEN{1'b0}}, b_mag_s};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        prod_d = mul_next_s;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_MUL;
        end
      end

`ifdef DIVIDER_EN
      ST_DIV: begin
        div_step_s = 1'b1;
        cnt_d      = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
`endif

      ST_FIX: begin
        result_d = fix_res_s;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      f3_q      <= 3'b000;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef DIVIDER_EN
  // Remainder sign flag (sign of the dividend), only needed with the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      rneg_q <= 1'b0;
    end else begin
      rneg_q <= rneg_d;
    end
  end
`endif

  assign bus.ready_out   = ready_q;
  assign bus.busy_out    = busy_q;
  assign bus.done_out    = done_q;
  assign bus.result_out  = result_q;
  assign bus.illegal_out = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit (XLEN = 32). The driver pushes the expected
// result, illegal flag and completion cycle for each accepted request; a
// monitor on the falling edge pops and compares whenever done_out is high.
// Cycle numbering: the accept edge opens cycle N, so done_out seen in the
// period after the accept edge is cycle N+1.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int LAT_IT  = XLEN + 2;
  localparam int LAT_SP  = 1;
  localparam logic [6:0] F7_OK  = 7'b0000001;
  localparam logic [6:0] F7_BAD = 7'b0100000;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   done_cnt;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done_out === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done_out with result 0x%08h, expected none",
                 bus.result_out);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".result"},  bus.result_out, mon_e.res);
        check({mon_e.name, ".illegal"}, 32'(bus.illegal_out), 32'(mon_e.ill));
        check({mon_e.name, ".latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
        check({mon_e.name, ".ready_in_done"}, 32'(bus.ready_out), 32'd0);
      end
    end
  end

  // Issue one request, push its expectation, wait (bounded) for completion.
  task automatic run_op(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ei, input int el);
    exp_t e;
    int   guard;
    int   busy_low;
    guard = 0;
    @(negedge clk);
    while (bus.ready_out !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.ready_out !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.ready_timeout: got ready_out 0, expected 1", nm);
      return;
    end
    bus.func7    = f7;
    bus.func3    = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    e.name = nm;
    e.res  = er;
    e.ill  = ei;
    e.lat  = el;
    e.acc  = cyc;
    sb.push_back(e);
    busy_low = 0;
    guard    = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      if (bus.done_out !== 1'b1 && bus.busy_out !== 1'b1) busy_low++;
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.done_timeout: got no done_out in %0d cycles, expected one", nm, guard);
      sb.delete();
    end
    check({nm, ".busy_low_cycles"}, 32'(busy_low), 32'd0);
  endtask

  initial begin : stim
    int d0;
    int guard;
    cyc          = 0;
    n_cmp        = 0;
    n_fail       = 0;
    done_cnt     = 0;
    reset        = 1'b1;
    bus.start_in = 1'b0;
    bus.func7    = 7'd0;
    bus.func3    = 3'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.ready",   32'(bus.ready_out),   32'd1);
    check("reset.busy",    32'(bus.busy_out),    32'd0);
    check("reset.done",    32'(bus.done_out),    32'd0);
    check("reset.illegal", 32'(bus.illegal_out), 32'd0);
    check("reset.result",  bus.result_out,       32'd0);

    // Multiply
    run_op("mul_7_m3",      F7_OK, F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_IT);
    run_op("mulhu_ff_ff",   F7_OK, F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_IT);
    run_op("mulh_ff_ff",    F7_OK, F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_IT);
    run_op("mulhsu_m1_2",   F7_OK, F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, LAT_IT);
    run_op("mul_shift",     F7_OK, F3_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0, LAT_IT);
    run_op("mulh_min_min",  F7_OK, F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, LAT_IT);
    run_op("mulh_min_1",    F7_OK, F3_MULH,   32'h8000_0000,  32'd1,         32'hFFFF_FFFF, 1'b0, LAT_IT);
    run_op("mulhu_min_4",   F7_OK, F3_MULHU,  32'h8000_0000,  32'd4,         32'h0000_0002, 1'b0, LAT_IT);
    run_op("mul_zero",      F7_OK, F3_MUL,    32'd0,          32'd5,         32'd0,         1'b0, LAT_IT);
    run_op("illegal_f7",    F7_BAD, F3_MUL,   32'd3,          32'd4,         32'd0,         1'b1, LAT_SP);

`ifdef DIVIDER_EN
    run_op("div_m7_2",      F7_OK, F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, LAT_IT);
    run_op("rem_m7_2",      F7_OK, F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, LAT_IT);
    run_op("divu_100_7",    F7_OK, F3_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, LAT_IT);
    run_op("remu_100_7",    F7_OK, F3_REMU, 32'd100,       32'd7,         32'd2,         1'b0, LAT_IT);
    run_op("div_7_m2",      F7_OK, F3_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT_IT);
    run_op("rem_7_m2",      F7_OK, F3_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, LAT_IT);
    run_op("divu_max_1",    F7_OK, F3_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, LAT_IT);
    run_op("divu_min_max",  F7_OK, F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, LAT_IT);
    run_op("divu_by0",      F7_OK, F3_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, LAT_SP);
    run_op("remu_by0",      F7_OK, F3_REMU, 32'd100,       32'd0,         32'd100,       1'b0, LAT_SP);
    run_op("div_m5_by0",    F7_OK, F3_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b0, LAT_SP);
    run_op("rem_m5_by0",    F7_OK, F3_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0, LAT_SP);
    run_op("div_ovf",       F7_OK, F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_SP);
    run_op("rem_ovf",       F7_OK, F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, LAT_SP);
`else
    run_op("div_disabled",  F7_OK, F3_DIV,  32'd10,        32'd2,         32'd0,         1'b1, LAT_SP);
    run_op("remu_disabled", F7_OK, F3_REMU, 32'd100,       32'd7,         32'd0,         1'b1, LAT_SP);
`endif
    run_op("illegal_f7_div", F7_BAD, F3_DIV, 32'd10,       32'd2,         32'd0,         1'b1, LAT_SP);

    // start_in while busy is ignored; the original result survives.
    d0 = done_cnt;
    @(negedge clk);
    bus.func7    = F7_OK;
    bus.func3    = F3_MULHU;
    bus.op_a     = 32'hFFFF_FFFF;
    bus.op_b     = 32'hFFFF_FFFF;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    mon_e.name = "busy_ignore";
    mon_e.res  = 32'hFFFF_FFFE;
    mon_e.ill  = 1'b0;
    mon_e.lat  = LAT_IT;
    mon_e.acc  = cyc;
    sb.push_back(mon_e);
    repeat (5) @(negedge clk);
    bus.func3    = F3_MUL;
    bus.op_a     = 32'd2;
    bus.op_b     = 32'd3;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    repeat (40) @(negedge clk);
    check("busy_ignore.done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_ignore.result_held", bus.result_out, 32'hFFFF_FFFE);
    sb.delete();

    // Reset 10 cycles into a multiply aborts it without a completion.
    @(negedge clk);
    bus.func3    = F3_MUL;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd5;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    d0    = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    check("abort.ready",  32'(bus.ready_out), 32'd1);
    check("abort.busy",   32'(bus.busy_out),  32'd0);
    check("abort.result", bus.result_out,     32'd0);
    repeat (40) @(negedge clk);
    check("abort.no_done", 32'(done_cnt - d0), 32'd0);

    // Unit is usable again after the abort.
    run_op("after_abort",   F7_OK, F3_MUL,  32'd6,         32'd7,         32'd42,        1'b0, LAT_IT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
